// File: rtl/seg_display_scanner_if.sv
// Front-panel display bus: shadow-buffer writes and commit requests in,
// scan status and multiplexed anode/segment drives out.
interface seg_display_scanner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int PWM_BITS   = 3
);
    localparam int DW = $clog2(NUM_DIGITS);

    logic                  wr_en;
    logic [DW-1:0]         wr_digit;
    logic [7:0]            wr_seg;
    logic                  wr_blink;
    logic                  commit;
    logic [PWM_BITS-1:0]   brightness;
    logic                  commit_pend;
    logic                  frame_tick;
    logic [NUM_DIGITS-1:0] an;
    logic [7:0]            seg;

    modport master (
        output wr_en, wr_digit, wr_seg, wr_blink, commit, brightness,
        input  commit_pend, frame_tick, an, seg
    );

    modport slave (
        input  wr_en, wr_digit, wr_seg, wr_blink, commit, brightness,
        output commit_pend, frame_tick, an, seg
    );
endinterface

// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment scanner with a shadow/active buffer pair, per-digit blink,
// PWM brightness and a one-cycle blank at every digit change.
//
// Commit FSM
//   state   | meaning
//   ST_IDLE | no commit outstanding; active buffer stable
//   ST_PEND | commit requested; shadow copied to active at next frame boundary
module seg_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 200000,
    parameter int BLINK_DIV  = 64,
    parameter int PWM_BITS   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg_display_scanner_if.slave   bus
);
    localparam int   DW  = $clog2(NUM_DIGITS);
    localparam int   PW  = $clog2(SCAN_DIV);
    localparam int   BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    typedef enum logic {ST_IDLE, ST_PEND} commit_state_t;

    commit_state_t         r_state, w_state_next;
    logic                  w_swap;

    logic [PW-1:0]         r_presc;
    logic [DW-1:0]         r_digit;
    logic [PWM_BITS-1:0]   r_pwm;
    logic [BW-1:0]         r_frame_cnt;
    logic                  r_blink_phase;
    logic                  r_frame_tick;

    logic [7:0]            r_shadow_seg [NUM_DIGITS];
    logic [7:0]            r_active_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_shadow_blink;
    logic [NUM_DIGITS-1:0] r_active_blink;

    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_seg;

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_wr_ok;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic [7:0]            w_seg_next;

    assign w_tick     = (r_presc == PW'(SCAN_DIV - 1));
    assign w_boundary = w_tick && (r_digit == DW'(NUM_DIGITS - 1));
    assign w_wr_ok    = bus.wr_en && ({1'b0, bus.wr_digit} < (DW + 1)'(NUM_DIGITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A commit arriving in the boundary cycle itself re-arms for the next frame.
    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.commit) w_state_next = ST_PEND;
            end
            ST_PEND: begin
                if (w_boundary) begin
                    w_swap       = 1'b1;
                    w_state_next = bus.commit ? ST_PEND : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_digit       <= '0;
            r_pwm         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_frame_tick  <= 1'b0;
        end else begin
            r_pwm        <= r_pwm + PWM_BITS'(1);
            r_frame_tick <= w_boundary;
            if (w_tick) begin
                r_presc <= '0;
                r_digit <= (r_digit == DW'(NUM_DIGITS - 1)) ? '0 : r_digit + DW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            if (w_boundary) begin
                if (r_frame_cnt == BW'(BLINK_DIV - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + BW'(1);
                end
            end
        end
    end

    // The swap reads pre-edge shadow, so a same-cycle write waits for the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow_seg[i] <= '0;
                r_active_seg[i] <= '0;
            end
            r_shadow_blink <= '0;
            r_active_blink <= '0;
        end else begin
            if (w_swap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_active_seg[i] <= r_shadow_seg[i];
                end
                r_active_blink <= r_shadow_blink;
            end
            if (w_wr_ok) begin
                r_shadow_seg[bus.wr_digit]   <= bus.wr_seg;
                r_shadow_blink[bus.wr_digit] <= bus.wr_blink;
            end
        end
    end

    always_comb begin
        w_an_next  = '0;
        w_seg_next = '0;
        if (!w_tick) begin
            if (r_pwm <= bus.brightness) begin
                w_an_next = NUM_DIGITS'(1) << r_digit;
            end
            if (!(r_active_blink[r_digit] && r_blink_phase)) begin
                w_seg_next = r_active_seg[r_digit];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= {NUM_DIGITS{POL}};
            r_seg <= {8{POL}};
        end else begin
            r_an  <= w_an_next ^ {NUM_DIGITS{POL}};
            r_seg <= w_seg_next ^ {8{POL}};
        end
    end

    assign bus.commit_pend = (r_state == ST_PEND);
    assign bus.frame_tick  = r_frame_tick;
    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
endmodule
